// File: rtl/video_pkg.sv
// Shared types and constants for the video index RAM write path.
package video_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    function automatic int unsigned frame_pixels(input int unsigned h_active,
                                                 input int unsigned v_active);
        return h_active * v_active;
    endfunction

endpackage

// File: rtl/video_adr_calc.sv
// Two-stage coordinate-to-linear-address pipeline: S1 captures and range-checks,
// S2 presents the row-major address y*H_ACTIVE+x with the pixel data.
module video_adr_calc
    import video_pkg::*;
#(
    parameter int HCW      = 12,
    parameter int VCW      = 12,
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 600,
    parameter int IMAW     = 19,
    parameter int IMDW     = 8
) (
    input  logic            clk,
    input  logic            clk_en,
    input  logic            rst,
    input  logic            in_vld,
    input  logic [HCW-1:0]  in_x,
    input  logic [VCW-1:0]  in_y,
    input  logic [IMDW-1:0] in_dat,
    output logic            s1_vld,
    output logic            s1_in_range,
    output logic            s2_vld,
    output logic            s2_in_range,
    output logic [IMAW-1:0] adr,
    output logic [IMDW-1:0] dat
);

    localparam int MW = HCW + VCW;
    localparam logic [HCW:0] H_LIM = (HCW+1)'(H_ACTIVE);
    localparam logic [VCW:0] V_LIM = (VCW+1)'(V_ACTIVE);

    logic [HCW-1:0]  s1_x;
    logic [VCW-1:0]  s1_y;
    logic [IMDW-1:0] s1_dat;
    logic [MW-1:0]   lin_adr;

    // Full-width product first; the RAM only sees the low IMAW bits.
    assign lin_adr = MW'(s1_y) * MW'(H_ACTIVE) + MW'(s1_x);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld      <= 1'b0;
            s1_in_range <= 1'b0;
            s1_x        <= '0;
            s1_y        <= '0;
            s1_dat      <= '0;
            s2_vld      <= 1'b0;
            s2_in_range <= 1'b0;
            adr         <= '0;
            dat         <= '0;
        end else if (clk_en) begin
            s1_vld      <= in_vld;
            s1_in_range <= ({1'b0, in_x} < H_LIM) && ({1'b0, in_y} < V_LIM);
            s1_x        <= in_x;
            s1_y        <= in_y;
            s1_dat      <= in_dat;
            s2_vld      <= s1_vld;
            s2_in_range <= s1_in_range;
            adr         <= IMAW'(lin_adr);
            dat         <= s1_dat;
        end
    end

endmodule

// File: rtl/video_ram_writer.sv
// Write-side front end of the video index RAM: pixel writes, full-frame clear
// sweep and frame-complete signalling.
//
//   state    | meaning
//   ST_IDLE  | accepting pixels; clr_req && en starts a clear
//   ST_FLUSH | pixel input blocked, waiting for the address pipeline to drain
//   ST_CLEAR | writing clr_val to every frame address, one per clk_en cycle
module video_ram_writer
    import video_pkg::*;
#(
    parameter int HCW      = 12,
    parameter int VCW      = 12,
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 600,
    parameter int IMAW     = 19,
    parameter int IMDW     = 8
) (
    input  logic            clk,
    input  logic            clk_en,
    input  logic            rst,
    input  logic            en,
    input  logic            clr_req,
    input  logic [IMDW-1:0] clr_val,
    input  logic            in_vld,
    output logic            in_rdy,
    input  logic [HCW-1:0]  in_x,
    input  logic [VCW-1:0]  in_y,
    input  logic [IMDW-1:0] in_dat,
    output logic            vram_we,
    output logic [IMAW-1:0] vram_adr_w,
    output logic [IMDW-1:0] vram_dat_w,
    output logic            busy,
    output logic            clr_done,
    output logic            frame_done,
    output logic            drop
);

    localparam int unsigned     FP       = frame_pixels(H_ACTIVE, V_ACTIVE);
    localparam logic [IMAW-1:0] LAST_ADR = IMAW'(FP - 1);

    state_t          state;
    logic [IMAW-1:0] clr_adr;
    logic [IMAW-1:0] pix_cnt;
    logic            clr_we;
    logic [IMAW-1:0] clr_wadr;
    logic [IMDW-1:0] clr_wdat;

    logic            s1_vld;
    logic            s1_in_range;
    logic            s2_vld;
    logic            s2_in_range;
    logic [IMAW-1:0] pix_adr;
    logic [IMDW-1:0] pix_dat;

    assign in_rdy = en && (state == ST_IDLE) && !clr_req;
    assign busy   = (state != ST_IDLE) || s1_vld || s2_vld;

    video_adr_calc #(
        .HCW      (HCW),
        .VCW      (VCW),
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .IMAW     (IMAW),
        .IMDW     (IMDW)
    ) u_adr_calc (
        .clk         (clk),
        .clk_en      (clk_en),
        .rst         (rst),
        .in_vld      (in_vld && in_rdy),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_dat      (in_dat),
        .s1_vld      (s1_vld),
        .s1_in_range (s1_in_range),
        .s2_vld      (s2_vld),
        .s2_in_range (s2_in_range),
        .adr         (pix_adr),
        .dat         (pix_dat)
    );

    // Pixel writes and clear writes never overlap: the clear only starts once
    // the pipeline is empty, so a plain OR/mux of the two registered sources is safe.
    assign vram_we    = (s2_vld && s2_in_range) || clr_we;
    assign vram_adr_w = clr_we ? clr_wadr : pix_adr;
    assign vram_dat_w = clr_we ? clr_wdat : pix_dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            clr_adr    <= '0;
            pix_cnt    <= '0;
            clr_we     <= 1'b0;
            clr_wadr   <= '0;
            clr_wdat   <= '0;
            clr_done   <= 1'b0;
            frame_done <= 1'b0;
            drop       <= 1'b0;
        end else if (clk_en) begin
            clr_we     <= 1'b0;
            clr_done   <= 1'b0;
            frame_done <= 1'b0;
            drop       <= s1_vld && !s1_in_range;

            if (s1_vld && s1_in_range) begin
                if (pix_cnt == LAST_ADR) begin
                    pix_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (clr_req && en) state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (!en) begin
                        state   <= ST_IDLE;
                        clr_adr <= '0;
                    end else if (!s1_vld && !s2_vld) begin
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (!en) begin
                        state   <= ST_IDLE;
                        clr_adr <= '0;
                    end else begin
                        clr_we   <= 1'b1;
                        clr_wadr <= clr_adr;
                        clr_wdat <= clr_val;
                        if (clr_adr == LAST_ADR) begin
                            clr_done <= 1'b1;
                            clr_adr  <= '0;
                            pix_cnt  <= '0;
                            state    <= ST_IDLE;
                        end else begin
                            clr_adr <= clr_adr + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
